// File: rtl/cache_tag_lru_if.sv
// Request/response bundle between the L2 controller (master) and the tag/LRU store (slave).
// A request transfers on a rising edge where req_valid && req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface cache_tag_lru_if #(
    parameter int INDEX_BITS = 14,
    parameter int TAG_BITS   = 12,
    parameter int WAYS       = 8
);
    localparam int AGE_BITS = $clog2(WAYS);

    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            req_mesi;

    logic                  resp_valid;
    logic                  resp_hit;
    logic [AGE_BITS-1:0]   resp_way;
    logic [1:0]            resp_mesi;
    logic [TAG_BITS-1:0]   resp_victim_tag;
    logic                  resp_writeback;

    modport master (
        output req_valid, req_op, req_index, req_tag, req_mesi,
        input  req_ready,
        input  resp_valid, resp_hit, resp_way, resp_mesi, resp_victim_tag, resp_writeback
    );

    modport slave (
        input  req_valid, req_op, req_index, req_tag, req_mesi,
        output req_ready,
        output resp_valid, resp_hit, resp_way, resp_mesi, resp_victim_tag, resp_writeback
    );
endinterface

// File: rtl/cache_tag_lru.sv
// Set-associative tag/MESI/true-LRU store with self-initialisation, one request per cycle,
// registered one-cycle response, victim selection and writeback flagging.
module cache_tag_lru #(
    parameter int INDEX_BITS = 14,
    parameter int TAG_BITS   = 12,
    parameter int WAYS       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_tag_lru_if.slave   bus,
    output logic             dbgState
);
    localparam int AGE_BITS = $clog2(WAYS);
    localparam int SETS     = 1 << INDEX_BITS;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_SNOOP = 2'b11;
    localparam logic [1:0] MESI_I   = 2'b00;
    localparam logic [1:0] MESI_M   = 2'b11;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} stateT;

    stateT                 state, stateNext;
    logic [INDEX_BITS-1:0] initCnt;

    logic [TAG_BITS-1:0]   tagMem  [SETS][WAYS];
    logic [1:0]            mesiMem [SETS][WAYS];
    logic [AGE_BITS-1:0]   ageMem  [SETS][WAYS];

    logic                  accept;
    logic                  s1Valid;
    logic [1:0]            s1Op;
    logic [INDEX_BITS-1:0] s1Index;
    logic [TAG_BITS-1:0]   s1Tag;
    logic [1:0]            s1Mesi;

    logic [TAG_BITS-1:0]   curTag  [WAYS];
    logic [1:0]            curMesi [WAYS];
    logic [AGE_BITS-1:0]   curAge  [WAYS];
    logic [TAG_BITS-1:0]   nxtTag  [WAYS];
    logic [1:0]            nxtMesi [WAYS];
    logic [AGE_BITS-1:0]   nxtAge  [WAYS];

    logic                  hit, freeFound;
    logic [AGE_BITS-1:0]   hitWay, freeWay, oldestWay, victimWay, selWay, touchAge;
    logic                  doTouch, doMesi, doTag, wbNext;
    logic [1:0]            newMesi;

    // Init walks every set once after reset; requests are refused until it finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            initCnt <= '0;
        end else begin
            state <= stateNext;
            if (state == ST_INIT) initCnt <= initCnt + 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        if (state == ST_INIT && initCnt == {INDEX_BITS{1'b1}}) stateNext = ST_RUN;
    end

    assign dbgState      = state;
    assign bus.req_ready = (state == ST_RUN);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Op    <= OP_READ;
            s1Index <= '0;
            s1Tag   <= '0;
            s1Mesi  <= MESI_I;
        end else begin
            s1Valid <= accept;
            if (accept) begin
                s1Op    <= bus.req_op;
                s1Index <= bus.req_index;
                s1Tag   <= bus.req_tag;
                s1Mesi  <= bus.req_mesi;
            end
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            curTag[w]  = tagMem[s1Index][w];
            curMesi[w] = mesiMem[s1Index][w];
            curAge[w]  = ageMem[s1Index][w];
        end
    end

    // Lookup and victim choice: a free (I) way is always preferred over the LRU way.
    always_comb begin
        hit       = 1'b0;
        hitWay    = '0;
        freeFound = 1'b0;
        freeWay   = '0;
        oldestWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (curMesi[w] != MESI_I && curTag[w] == s1Tag) begin
                hit    = 1'b1;
                hitWay = AGE_BITS'(w);
            end
            if (curAge[w] == AGE_BITS'(WAYS - 1)) oldestWay = AGE_BITS'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (curMesi[w] == MESI_I) begin
                freeFound = 1'b1;
                freeWay   = AGE_BITS'(w);
            end
        end
        victimWay = freeFound ? freeWay : oldestWay;
    end

    always_comb begin
        selWay  = hit ? hitWay : victimWay;
        doTouch = 1'b0;
        doMesi  = 1'b0;
        doTag   = 1'b0;
        wbNext  = 1'b0;
        newMesi = s1Mesi;
        case (s1Op)
            OP_READ: doTouch = hit;
            OP_WRITE: begin
                doTouch = hit;
                doMesi  = hit;
                newMesi = MESI_M;
            end
            OP_FILL: begin
                doTouch = 1'b1;
                doMesi  = 1'b1;
                doTag   = !hit;
                wbNext  = !hit && (curMesi[victimWay] == MESI_M);
            end
            default: begin
                doMesi = hit;
                if (!hit) selWay = '0;
            end
        endcase
    end

    // Touch: ways younger than the touched way age by one, the touched way becomes 0.
    always_comb begin
        touchAge = curAge[selWay];
        for (int w = 0; w < WAYS; w++) begin
            nxtTag[w]  = curTag[w];
            nxtMesi[w] = curMesi[w];
            nxtAge[w]  = curAge[w];
            if (doTouch) begin
                if (AGE_BITS'(w) == selWay) nxtAge[w] = '0;
                else if (curAge[w] < touchAge) nxtAge[w] = curAge[w] + 1'b1;
            end
            if (AGE_BITS'(w) == selWay) begin
                if (doMesi) nxtMesi[w] = newMesi;
                if (doTag)  nxtTag[w]  = s1Tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            for (int w = 0; w < WAYS; w++) begin
                tagMem[initCnt][w]  <= '0;
                mesiMem[initCnt][w] <= MESI_I;
                ageMem[initCnt][w]  <= AGE_BITS'(w);
            end
        end else if (s1Valid) begin
            for (int w = 0; w < WAYS; w++) begin
                tagMem[s1Index][w]  <= nxtTag[w];
                mesiMem[s1Index][w] <= nxtMesi[w];
                ageMem[s1Index][w]  <= nxtAge[w];
            end
        end
    end

    // Response fields hold their previous values on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid      <= 1'b0;
            bus.resp_hit        <= 1'b0;
            bus.resp_way        <= '0;
            bus.resp_mesi       <= MESI_I;
            bus.resp_victim_tag <= '0;
            bus.resp_writeback  <= 1'b0;
        end else begin
            bus.resp_valid <= s1Valid;
            if (s1Valid) begin
                bus.resp_hit        <= hit;
                bus.resp_way        <= selWay;
                bus.resp_mesi       <= curMesi[selWay];
                bus.resp_victim_tag <= curTag[selWay];
                bus.resp_writeback  <= wbNext;
            end
        end
    end
endmodule

// File: tb/tb_cache_tag_lru.sv
// Directed bench for cache_tag_lru: driver pushes hand-computed responses into a queue,
// a negedge monitor pops and compares them together with the response cycle.
module tb_cache_tag_lru;
    localparam int IB = 4;
    localparam int TB = 8;
    localparam int NW = 4;

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, FL = 2'b10, SN = 2'b11;
    localparam logic [1:0] MI = 2'b00, MS = 2'b01, ME = 2'b10, MM = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbgState;
    always #5 clk = ~clk;

    cache_tag_lru_if #(.INDEX_BITS(IB), .TAG_BITS(TB), .WAYS(NW)) bus ();

    cache_tag_lru #(.INDEX_BITS(IB), .TAG_BITS(TB), .WAYS(NW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // {hit, way, mesi, victim_tag, writeback}
    logic [13:0] expQ[$];
    int          expCycQ[$];
    int          cycle = 0;
    int          nApplied = 0;
    int          nMiscompares = 0;
    logic [13:0] gotVec, expVec;
    int          expCyc;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nApplied++;
        if (act !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            gotVec = {bus.resp_hit, bus.resp_way, bus.resp_mesi, bus.resp_victim_tag, bus.resp_writeback};
            nApplied++;
            if (expQ.size() == 0) begin
                nMiscompares++;
                $display("FAIL unexpected_resp: got %h with no request outstanding", gotVec);
            end else begin
                expVec = expQ.pop_front();
                expCyc = expCycQ.pop_front();
                if (gotVec !== expVec || cycle != expCyc) begin
                    nMiscompares++;
                    $display("FAIL resp: got hit=%b way=%0d mesi=%0d vtag=%h wb=%b cyc=%0d expected hit=%b way=%0d mesi=%0d vtag=%h wb=%b cyc=%0d",
                             gotVec[13], gotVec[12:11], gotVec[10:9], gotVec[8:1], gotVec[0], cycle,
                             expVec[13], expVec[12:11], expVec[10:9], expVec[8:1], expVec[0], expCyc);
                end
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the request accepted in between.
    task automatic issue(input logic [1:0] op, input logic [IB-1:0] idx, input logic [TB-1:0] tag,
                         input logic [1:0] mesi, input logic eHit, input logic [1:0] eWay,
                         input logic [1:0] eMesi, input logic [TB-1:0] eTag, input logic eWb);
        int guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) check("ready_timeout", 0, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_index = idx;
        bus.req_tag   = tag;
        bus.req_mesi  = mesi;
        expQ.push_back({eHit, eWay, eMesi, eTag, eWb});
        expCycQ.push_back(cycle + 2);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic waitInit(input string name);
        int cnt = 0;
        while (!bus.req_ready && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check(name, cnt, 16);
        check("dbg_state_run", dbgState, 1);
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        check("queue_drain", expQ.size(), 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = RD;
        bus.req_index = '0;
        bus.req_tag   = '0;
        bus.req_mesi  = MI;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_hit", bus.resp_hit, 0);
        check("rst_resp_way", bus.resp_way, 0);
        check("rst_resp_mesi", bus.resp_mesi, MI);
        check("rst_resp_vtag", bus.resp_victim_tag, 0);
        check("rst_resp_wb", bus.resp_writeback, 0);
        check("rst_dbg_state", dbgState, 0);
        rst_n = 1'b1;
        waitInit("init_cycles");

        issue(RD, 4'd3, 8'h5A, MI, 0, 2'd0, MI, 8'h00, 0);

        // Fill a set, then replace the oldest way
        issue(FL, 4'd2, 8'h10, ME, 0, 2'd0, MI, 8'h00, 0);
        issue(FL, 4'd2, 8'h11, ME, 0, 2'd1, MI, 8'h00, 0);
        issue(FL, 4'd2, 8'h12, ME, 0, 2'd2, MI, 8'h00, 0);
        issue(FL, 4'd2, 8'h13, ME, 0, 2'd3, MI, 8'h00, 0);
        issue(FL, 4'd2, 8'h14, ME, 0, 2'd0, ME, 8'h10, 0);

        // A read touch moves the victim to way 1
        issue(FL, 4'd4, 8'h10, ME, 0, 2'd0, MI, 8'h00, 0);
        issue(FL, 4'd4, 8'h11, ME, 0, 2'd1, MI, 8'h00, 0);
        issue(FL, 4'd4, 8'h12, ME, 0, 2'd2, MI, 8'h00, 0);
        issue(FL, 4'd4, 8'h13, ME, 0, 2'd3, MI, 8'h00, 0);
        issue(RD, 4'd4, 8'h10, MI, 1, 2'd0, ME, 8'h10, 0);
        issue(FL, 4'd4, 8'h14, ME, 0, 2'd1, ME, 8'h11, 0);

        // Write upgrade then dirty eviction
        issue(FL, 4'd5, 8'h20, MS, 0, 2'd0, MI, 8'h00, 0);
        issue(WR, 4'd5, 8'h20, MI, 1, 2'd0, MS, 8'h20, 0);
        issue(FL, 4'd5, 8'h21, ME, 0, 2'd1, MI, 8'h00, 0);
        issue(FL, 4'd5, 8'h22, ME, 0, 2'd2, MI, 8'h00, 0);
        issue(FL, 4'd5, 8'h23, ME, 0, 2'd3, MI, 8'h00, 0);
        issue(FL, 4'd5, 8'h24, ME, 0, 2'd0, MM, 8'h20, 1);
        issue(WR, 4'd5, 8'h99, MI, 0, 2'd1, ME, 8'h21, 0);
        issue(RD, 4'd5, 8'h24, MI, 1, 2'd0, ME, 8'h24, 0);

        // Snoop invalidate frees a way that the next fill reuses
        issue(FL, 4'd7, 8'h30, ME, 0, 2'd0, MI, 8'h00, 0);
        issue(FL, 4'd7, 8'h31, ME, 0, 2'd1, MI, 8'h00, 0);
        issue(FL, 4'd7, 8'h32, ME, 0, 2'd2, MI, 8'h00, 0);
        issue(FL, 4'd7, 8'h33, ME, 0, 2'd3, MI, 8'h00, 0);
        issue(SN, 4'd7, 8'h32, MI, 1, 2'd2, ME, 8'h32, 0);
        issue(FL, 4'd7, 8'h34, MM, 0, 2'd2, MI, 8'h32, 0);
        issue(SN, 4'd7, 8'h77, MS, 0, 2'd0, ME, 8'h30, 0);
        issue(FL, 4'd7, 8'h34, MS, 1, 2'd2, MM, 8'h34, 0);
        issue(RD, 4'd7, 8'h30, MI, 1, 2'd0, ME, 8'h30, 0);
        issue(FL, 4'd7, 8'h35, ME, 0, 2'd1, ME, 8'h31, 0);
        drain();

        // Reset lands while a response is on the bus
        bus.req_valid = 1'b1;
        bus.req_op    = RD;
        bus.req_index = 4'd2;
        bus.req_tag   = 8'h14;
        bus.req_mesi  = MI;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("midop_resp_valid_before", bus.resp_valid, 1);
        check("midop_resp_hit_before", bus.resp_hit, 1);
        rst_n = 1'b0;
        #1;
        check("midop_resp_valid_async", bus.resp_valid, 0);
        check("midop_req_ready", bus.req_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitInit("reinit_cycles");
        issue(RD, 4'd2, 8'h14, MI, 0, 2'd0, MI, 8'h00, 0);
        issue(RD, 4'd7, 8'h30, MI, 0, 2'd0, MI, 8'h00, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end
endmodule
